bp_gshare: RTL
==============

Name: bp_gshare

Overview:
- Parametrised successor to the fetch-stage bimodal predictor; sits between the instruction fetcher and the ROB commit port.
- Predicts B-type direction from a table of saturating counters, indexed by PC, optionally XORed with a global history register (gshare mode).
- Predicts JAL targets unconditionally.
- Keeps a speculative history, repaired on mispredict, and saturating branch/miss statistics counters.

Parameters:
- IDX_W, 7, PHT index bits; the table has 2^IDX_W entries.
- CNT_W, 2, counter width, 2..4.
- HIST_W, 6, global history length, 1..IDX_W.
- MODE, 1, 0 = bimodal (history ignored for indexing), 1 = gshare.
- STAT_W, 32, statistics counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global enable; state frozen when low
- if_valid  in  1  fetcher accepts if_inst this cycle
- if_pc  in  32  fetch PC
- if_inst  in  32  fetched instruction
- predict_res  out  1  predicted taken
- predict_pc  out  32  predicted next PC
- predict_ghr  out  HIST_W  speculative history snapshot, carried with the instruction to the ROB
- rob_valid  in  1  a B-type branch commits this cycle
- commit_pc  in  32  PC of the committing branch
- commit_taken  in  1  actual direction
- commit_ghr  in  HIST_W  snapshot captured at fetch
- commit_mispredict  in  1  prediction was wrong; fetch is being flushed
- stat_branches  out  STAT_W  committed branch count
- stat_misses  out  STAT_W  mispredict count

Behaviour:
- Opcode is if_inst[6:0]. B_type and JAL opcode constants come from const_def.
- Fetch index:
  - MODE=1: if_pc[IDX_W+1:2] XOR zero-extended spec_ghr.
  - MODE=0: if_pc[IDX_W+1:2].
- Commit index: same formula, using commit_pc and commit_ghr.
- predict_res (combinational):
  - B-type: counter MSB.
  - JAL: 1.
  - Otherwise: 0.
- predict_pc (combinational):
  - B-type taken: if_pc + sign-extended B-immediate.
  - JAL: if_pc + sign-extended J-immediate {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - Otherwise: if_pc + 4.
  - Arithmetic is 32-bit and wraps modulo 2^32.
- predict_ghr = spec_ghr (combinational).
- Counter update, on posedge when rdy && rob_valid:
  - Taken: increment, saturating at 2^CNT_W-1.
  - Not taken: decrement, saturating at 0.
- History update, on posedge when rdy:
  - rob_valid && commit_mispredict: spec_ghr <= {commit_ghr[HIST_W-2:0], commit_taken}. This has priority; a same-cycle fetch is wrong-path and is ignored.
  - Otherwise, if_valid && B-type: spec_ghr <= {spec_ghr[HIST_W-2:0], predict_res}.
  - JAL and non-branches never shift history.
  - For HIST_W=1 the shifted register is just the new bit.
- Statistics, on posedge when rdy && rob_valid:
  - stat_branches += 1.
  - If commit_mispredict, stat_misses += 1.
  - Both saturate at all-ones; no wrap.
- Same-cycle read/write of the same entry: prediction uses the pre-update value. The write lands at the clock edge.
- rdy low: no state changes. Combinational outputs still track inputs.
- Reset (asynchronous, any cycle, including mid-update):
  - Every counter = 2^(CNT_W-1)-1 (weakly not-taken; 01 for CNT_W=2).
  - spec_ghr = 0; stat_branches = stat_misses = 0.
  - Hence predict_res = 0 for B-type, and predict_pc = if_pc+4, immediately after reset.

Decomposition:
- Opcode constants (B_type, JAL) and the immediate-extraction functions belong in shared const_def.
- One sub-module: bp_sat_counter_table (PHT array with read port, saturating update port, asynchronous reset init).
- History register, index hashing, target adder and statistics stay in bp_gshare.

Test Plan:
- Reset then B-type fetch at pc 0x100, imm +16 -> predict_res=0, predict_pc=0x104, predict_ghr=0.
- MODE=0: commit pc 0x100 taken twice (counter 01->10->11), then fetch -> predict_res=1, predict_pc=0x110. Third taken commit keeps counter at 11. Four not-taken commits -> 00, saturate.
- MODE=1, HIST_W=6: fetch B-types with predictions 1,0,1 -> predict_ghr=0b000101. Same-cycle commit_mispredict with commit_ghr=0b000011, commit_taken=0 plus a B-type fetch -> spec_ghr=0b000110 (fetch ignored).
- JAL at 0x200, imm -8 -> predict_res=1, predict_pc=0x1F8, spec_ghr unchanged. Non-branch -> predict_res=0, pc+4.
- rdy=0 with rob_valid=1 for 5 cycles -> counters, history and stats unchanged. rst asserted mid-cycle between edges -> all state returns to reset values without a clock edge.
- STAT_W=4: 20 commits, 17 mispredicted -> stat_branches=15, stat_misses=15 (saturated).

Source files
------------

// File: rtl/const_def.sv
// Shared RV32 decode constants and immediate extraction helpers.
package const_def;

   localparam logic [6:0] B_TYPE = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;

   // B-type immediate: {inst[31], inst[7], inst[30:25], inst[11:8], 0}, sign-extended.
   function automatic logic signed [31:0] imm_b(input logic [31:0] inst);
      return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
   endfunction

   // J-type immediate: {inst[31], inst[19:12], inst[20], inst[30:21], 0}, sign-extended.
   function automatic logic signed [31:0] imm_j(input logic [31:0] inst);
      return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/bp_sat_counter_table.sv
// Pattern history table of saturating direction counters.
// Reads are combinational, so a same-cycle read of an entry being written sees the old value.
module bp_sat_counter_table #(
   parameter int IDX_W = 7,
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [CNT_W-1:0] rd_cnt,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_taken
);

   localparam int DEPTH = 1 << IDX_W;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_INIT = {1'b0, {(CNT_W-1){1'b1}}};

   logic [CNT_W-1:0] pht [DEPTH];

   // Move one step toward taken or not-taken, holding at either end.
   function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] cnt, input logic taken);
      if (taken)
         return (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
      else
         return (cnt == '0) ? cnt : cnt - CNT_W'(1);
   endfunction

   assign rd_cnt = pht[rd_idx];

   // Weakly-not-taken init on reset; otherwise train the committed entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) pht[i] <= CNT_INIT;
      end else if (wr_en) begin
         pht[wr_idx] <= sat_step(pht[wr_idx], wr_taken);
      end
   end

endmodule

// File: rtl/bp_gshare.sv
// Fetch-stage branch predictor: bimodal or gshare direction, JAL targets,
// speculative global history with commit-time repair, and saturating statistics.
module bp_gshare
   import const_def::*;
#(
   parameter int IDX_W  = 7,
   parameter int CNT_W  = 2,
   parameter int HIST_W = 6,
   parameter int MODE   = 1,
   parameter int STAT_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              if_valid,
   input  logic [31:0]       if_pc,
   input  logic [31:0]       if_inst,
   output logic              predict_res,
   output logic [31:0]       predict_pc,
   output logic [HIST_W-1:0] predict_ghr,
   input  logic              rob_valid,
   input  logic [31:0]       commit_pc,
   input  logic              commit_taken,
   input  logic [HIST_W-1:0] commit_ghr,
   input  logic              commit_mispredict,
   output logic [STAT_W-1:0] stat_branches,
   output logic [STAT_W-1:0] stat_misses
);

   localparam logic [STAT_W-1:0] STAT_MAX = '1;

   logic [HIST_W-1:0] spec_ghr;
   logic [IDX_W-1:0]  fetch_idx;
   logic [IDX_W-1:0]  commit_idx;
   logic [CNT_W-1:0]  pht_cnt;
   logic              is_b;
   logic              is_jal;
   logic              unused_commit_pc;

   // Shift a new outcome into the history; truncation drops the oldest bit (works for HIST_W=1).
   function automatic logic [HIST_W-1:0] shift_hist(input logic [HIST_W-1:0] h, input logic b);
      return HIST_W'({h, b});
   endfunction

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == STAT_MAX) ? v : v + STAT_W'(1);
   endfunction

   assign is_b   = (if_inst[6:0] == B_TYPE);
   assign is_jal = (if_inst[6:0] == JAL);

   assign fetch_idx  = (MODE == 1) ? (if_pc[IDX_W+1:2] ^ IDX_W'(spec_ghr))
                                   : if_pc[IDX_W+1:2];
   assign commit_idx = (MODE == 1) ? (commit_pc[IDX_W+1:2] ^ IDX_W'(commit_ghr))
                                   : commit_pc[IDX_W+1:2];

   // Only the index bits of the committing PC matter for training.
   assign unused_commit_pc = ^{commit_pc[31:IDX_W+2], commit_pc[1:0]};

   bp_sat_counter_table #(
      .IDX_W (IDX_W),
      .CNT_W (CNT_W)
   ) u_pht (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (fetch_idx),
      .rd_cnt   (pht_cnt),
      .wr_en    (rdy && rob_valid),
      .wr_idx   (commit_idx),
      .wr_taken (commit_taken)
   );

   assign predict_ghr = spec_ghr;

   // Direction and next-PC for the instruction being fetched.
   always_comb begin
      predict_res = 1'b0;
      predict_pc  = if_pc + 32'd4;
      if (is_b) begin
         predict_res = pht_cnt[CNT_W-1];
         if (pht_cnt[CNT_W-1]) predict_pc = if_pc + imm_b(if_inst);
      end else if (is_jal) begin
         predict_res = 1'b1;
         predict_pc  = if_pc + imm_j(if_inst);
      end
   end

   // Speculative history: mispredict repair wins over a (wrong-path) fetch in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spec_ghr <= '0;
      end else if (rdy) begin
         if (rob_valid && commit_mispredict)
            spec_ghr <= shift_hist(commit_ghr, commit_taken);
         else if (if_valid && is_b)
            spec_ghr <= shift_hist(spec_ghr, predict_res);
      end
   end

   // Committed-branch and mispredict counters, holding at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_branches <= '0;
         stat_misses   <= '0;
      end else if (rdy && rob_valid) begin
         stat_branches <= sat_inc(stat_branches);
         if (commit_mispredict) stat_misses <= sat_inc(stat_misses);
      end
   end

endmodule
